uart_rx: RTL and testbench

Serial receiver that consumes the line driven by the UART transmit stage. It oversamples `rx` at 16× using the shared `baud_tick` strobe and frames 8N1 characters: 1 start bit, 8 data bits LSB first, 1 stop bit. Each accepted byte is presented as a one-cycle `rx_valid` pulse. Stop-bit failures are flagged on `rx_frame_err`. The block sits between the pad/loopback line and the receive-side consumer (FIFO or register file).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive and transmit stages.
// The receiver's optional majority vote is enabled by UART_RX_MAJORITY_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage flop synchronizer for an asynchronous input; flops reset to 1.
// Reusable for any idle-high asynchronous line.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with one-cycle valid/frame-error pulses.
// Define UART_RX_MAJORITY_EN to vote each decision over three baud ticks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    rx_state_t r_state;
    rx_state_t w_state_nxt;

    logic              w_rx_s;
    logic              r_rx_s_d;
    logic              w_sample;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [7:0]        r_shift;

    logic w_enter;
    logic w_shift_en;
    logic w_valid_set;
    logic w_err_set;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two held tick samples plus the live one form the voting window.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else if (baud_tick) begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = maj3({r_hist, w_rx_s});
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_valid_set = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Edge, not level: a held-low line never restarts.
                if (r_rx_s_d && !w_rx_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (baud_tick && r_tick_cnt == MID_TICK) begin
                    w_state_nxt = w_sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_tick && r_tick_cnt == LAST_TICK) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick && r_tick_cnt == LAST_TICK) begin
                    w_state_nxt = IDLE;
                    w_valid_set = w_sample;
                    w_err_set   = !w_sample;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_enter = (w_state_nxt != r_state);
    assign rx_busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s_d     <= 1'b1;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            r_rx_s_d     <= w_rx_s;
            rx_valid     <= w_valid_set;
            rx_frame_err <= w_err_set;
            if (w_enter) begin
                r_tick_cnt <= '0;
            end else if (baud_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            // bit_cnt wraps 7 -> 0 on the last data bit.
            if (w_shift_en) begin
                r_shift   <= {w_sample, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_valid_set) begin
                rx_data <= r_shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx; baud tick every 4 clocks.
// Expected glitch result follows UART_RX_MAJORITY_EN.
module tb_uart_rx;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int         n_err = 0;
    int         n_chk = 0;
    int         tick_no = 0;
    logic [1:0] div = 2'd0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;
    exp_t       q[$];
    int         pulse_ticks[$];

    uart_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            div = div + 2'd1;
            baud_tick = (div == 2'd0);
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_no <= tick_no + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rx_valid || rx_frame_err)) begin
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            check("pulse_excl", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, rx_valid, rx_frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {30'd0, rx_valid, rx_frame_err},
                      {30'd0, !e.err, e.err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
            pulse_ticks.push_back(tick_no);
        end
        prev_pulse = rx_valid | rx_frame_err;
    end

    task automatic wait_tick();
        do @(posedge clk); while (!baud_tick);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int glitch_bit, input logic [7:0] exp_d);
        exp_t e;
        if (stop_bit) begin
            e = '{err: 1'b0, data: exp_d};
            last_good = exp_d;
        end else begin
            e = '{err: 1'b1, data: last_good};
        end
        q.push_back(e);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive_bit(d[i], 7);
                drive_bit(!d[i], 1);
                drive_bit(d[i], 8);
            end else begin
                drive_bit(d[i], 16);
            end
        end
        drive_bit(stop_bit, 16);
    endtask

    initial begin
        int         n0;
        logic [7:0] glitch_exp;
        logic [7:0] part;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        wait_tick();
        drive_bit(1'b1, 4);

        n0 = pulse_ticks.size();
        send_frame(8'hA5, 1'b1, -1, 8'hA5);
        drive_bit(1'b1, 4);
        check("a5_pulses", pulse_ticks.size() - n0, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);

        n0 = pulse_ticks.size();
        drive_bit(1'b0, 4);
        check("fs_busy_hi", {31'd0, rx_busy}, 32'd1);
        drive_bit(1'b1, 4);
        check("fs_busy_lo", {31'd0, rx_busy}, 32'd0);
        drive_bit(1'b1, 8);
        check("fs_no_pulse", pulse_ticks.size() - n0, 32'd0);
        send_frame(8'h3C, 1'b1, -1, 8'h3C);
        drive_bit(1'b1, 4);
        check("fs_3c_data", {24'd0, rx_data}, 32'h3C);

        send_frame(8'h11, 1'b1, -1, 8'h11);
        n0 = pulse_ticks.size();
        send_frame(8'h3C, 1'b0, -1, 8'h3C);
        drive_bit(1'b0, 40);
        check("fe_pulses", pulse_ticks.size() - n0, 32'd1);
        check("fe_busy", {31'd0, rx_busy}, 32'd0);
        check("fe_data", {24'd0, rx_data}, 32'h11);
        drive_bit(1'b1, 16);

        n0 = pulse_ticks.size();
        send_frame(8'h00, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, 8'hFF);
        drive_bit(1'b1, 4);
        check("b2b_pulses", pulse_ticks.size() - n0, 32'd2);
        if (pulse_ticks.size() - n0 == 2) begin
            check("b2b_gap", pulse_ticks[n0+1] - pulse_ticks[n0], 32'd160);
        end
        check("b2b_data", {24'd0, rx_data}, 32'hFF);

        part = 8'hC3;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(part[i], 16);
        drive_bit(part[3], 8);
        rst_n = 1'b0;
        #2;
        check("mr_data", {24'd0, rx_data}, 32'h00);
        check("mr_valid", {31'd0, rx_valid}, 32'd0);
        check("mr_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("mr_busy", {31'd0, rx_busy}, 32'd0);
        rx = 1'b1;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_tick();
        drive_bit(1'b1, 16);
        send_frame(8'h5A, 1'b1, -1, 8'h5A);
        drive_bit(1'b1, 4);
        check("mr_5a_data", {24'd0, rx_data}, 32'h5A);

`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h04;
`endif
        send_frame(8'h00, 1'b1, 2, glitch_exp);
        drive_bit(1'b1, 8);
        check("gl_data", {24'd0, rx_data}, {24'd0, glitch_exp});

        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
